// File: rtl/pipe_pkg.sv
// Shared types for the rv32i pipeline stage registers: handshake state encoding
// and the packed payload carried across each stage boundary.
package pipe_pkg;

    typedef logic [31:0] rv32i_word;
    typedef logic [6:0]  rv32i_opcode;
    typedef logic [31:0] rv32i_reg_word;
    typedef logic [4:0]  rv32i_reg_idx;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } if_id_t;

    typedef struct packed {
        rv32i_word     pc;
        rv32i_opcode   opcode;
        rv32i_reg_word rs1_data;
        rv32i_reg_word rs2_data;
        rv32i_word     imm;
        rv32i_reg_idx  rd;
    } id_ex_t;

    typedef struct packed {
        rv32i_word     pc;
        rv32i_opcode   opcode;
        rv32i_word     alu_out;
        rv32i_reg_word rs2_data;
        rv32i_reg_idx  rd;
    } ex_mem_t;

    typedef struct packed {
        rv32i_opcode   opcode;
        rv32i_reg_word wb_data;
        rv32i_reg_idx  rd;
    } mem_wb_t;

    function automatic logic [1:0] state_occupancy(input pipe_state_t state);
        case (state)
            PS_EMPTY: return 2'd0;
            PS_ONE:   return 2'd1;
            PS_FULL:  return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and flush. SKID=1 adds a
// second entry so in_ready comes from a register instead of from out_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter bit          SKID  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    generate
        if (SKID) begin : g_skid
            pipe_state_t      state_q, state_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic [WIDTH-1:0] skid_q, skid_d;
            logic             in_ready_s, out_valid_s, in_fire_s, out_fire_s;

            // next-state, data steering and handshake decode
            always_comb begin
                state_d     = state_q;
                main_d      = main_q;
                skid_d      = skid_q;
                in_ready_s  = (state_q != PS_FULL);
                out_valid_s = (state_q != PS_EMPTY);
                in_fire_s   = in_valid & in_ready_s;
                out_fire_s  = out_valid_s & out_ready;
                if (flush) begin
                    state_d = PS_EMPTY;
                end else begin
                    case (state_q)
                        PS_EMPTY: begin
                            if (in_fire_s) begin
                                state_d = PS_ONE;
                                main_d  = in_data;
                            end else begin
                                state_d = PS_EMPTY;
                            end
                        end
                        PS_ONE: begin
                            if (in_fire_s && out_fire_s) begin
                                state_d = PS_ONE;
                                main_d  = in_data;
                            end else if (in_fire_s) begin
                                // younger payload parks in the skid entry
                                state_d = PS_FULL;
                                skid_d  = in_data;
                            end else if (out_fire_s) begin
                                state_d = PS_EMPTY;
                            end else begin
                                state_d = PS_ONE;
                            end
                        end
                        PS_FULL: begin
                            if (out_fire_s) begin
                                state_d = PS_ONE;
                                main_d  = skid_q;
                            end else begin
                                state_d = PS_FULL;
                            end
                        end
                        default: begin
                            state_d = PS_EMPTY;
                        end
                    endcase
                end
            end

            // state and both data entries
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= PS_EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end

            assign in_ready  = in_ready_s;
            assign out_valid = out_valid_s;
            assign out_data  = main_q;
            assign occupancy = state_occupancy(state_q);
        end else begin : g_single
            pipe_state_t      state_q, state_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic             in_ready_s, out_valid_s, in_fire_s, out_fire_s;

            // next-state, data steering and handshake decode
            always_comb begin
                state_d     = state_q;
                main_d      = main_q;
                out_valid_s = (state_q != PS_EMPTY);
                // a consumer draining this cycle frees the single entry
                in_ready_s  = !out_valid_s | out_ready;
                in_fire_s   = in_valid & in_ready_s;
                out_fire_s  = out_valid_s & out_ready;
                if (flush) begin
                    state_d = PS_EMPTY;
                end else if (in_fire_s) begin
                    state_d = PS_ONE;
                    main_d  = in_data;
                end else if (out_fire_s) begin
                    state_d = PS_EMPTY;
                end else begin
                    state_d = state_q;
                end
            end

            // state and data entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= PS_EMPTY;
                    main_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                end
            end

            assign in_ready  = in_ready_s;
            assign out_valid = out_valid_s;
            assign out_data  = main_q;
            assign occupancy = state_occupancy(state_q);
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed vectors and a scoreboarded random soak for pipe_stage_skid, with a
// SKID=1 and a SKID=0 instance sharing the same input stimulus.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        ir1, ov1, ir0, ov0;
    logic [31:0] od1, od0;
    logic [1:0]  occ1, occ0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(32), .SKID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1)
    );

    pipe_stage_skid #(.WIDTH(32), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(occ0)
    );

    typedef struct packed {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic        ir;
        logic [1:0]  occ;
    } vec_t;

    function automatic logic [35:0] pk(input logic ov, input logic ir,
                                       input logic [1:0] occ, input logic [31:0] od);
        return {ov, ir, occ, od};
    endfunction

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {ov,ir,occ,data}=%h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t        vecs [22];
    logic [31:0] q1[$];
    logic [31:0] q0[$];

    initial begin
        logic        e1_ir, e1_ov, e0_ir, e0_ov;
        logic        iv, ordy, fl;
        logic [31:0] d;

        vecs[0]  = '{1'b1, 32'h00000013, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'd0};
        vecs[1]  = '{1'b1, 32'h00100093, 1'b1, 1'b0, 1'b1, 32'h00000013, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 32'h00200113, 1'b1, 1'b0, 1'b1, 32'h00100093, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00200113, 1'b1, 2'd1};
        vecs[4]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00200113, 1'b1, 2'd0};
        vecs[5]  = '{1'b1, 32'hAAAA0001, 1'b0, 1'b0, 1'b0, 32'h00200113, 1'b1, 2'd0};
        vecs[6]  = '{1'b1, 32'hBBBB0002, 1'b0, 1'b0, 1'b1, 32'hAAAA0001, 1'b1, 2'd1};
        vecs[7]  = '{1'b1, 32'hDEAD0000, 1'b0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0, 2'd2};
        vecs[8]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0, 2'd2};
        vecs[9]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0, 2'd2};
        vecs[10] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0, 2'd2};
        vecs[11] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0, 2'd2};
        vecs[12] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'hAAAA0001, 1'b0, 2'd2};
        vecs[13] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'hBBBB0002, 1'b1, 2'd1};
        vecs[14] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'hBBBB0002, 1'b1, 2'd0};
        vecs[15] = '{1'b1, 32'h11110001, 1'b0, 1'b0, 1'b0, 32'hBBBB0002, 1'b1, 2'd0};
        vecs[16] = '{1'b1, 32'h22220002, 1'b0, 1'b0, 1'b1, 32'h11110001, 1'b1, 2'd1};
        vecs[17] = '{1'b1, 32'hCCCC0003, 1'b0, 1'b1, 1'b1, 32'h11110001, 1'b0, 2'd2};
        vecs[18] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h11110001, 1'b1, 2'd0};
        vecs[19] = '{1'b1, 32'h33330003, 1'b0, 1'b0, 1'b0, 32'h11110001, 1'b1, 2'd0};
        vecs[20] = '{1'b1, 32'hCCCC0003, 1'b1, 1'b1, 1'b1, 32'h33330003, 1'b1, 2'd1};
        vecs[21] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h33330003, 1'b1, 2'd0};

        do_reset();
        chk("reset_skid1", pk(ov1, ir1, occ1, od1), pk(1'b0, 1'b1, 2'd0, 32'h0));
        chk("reset_skid0", pk(ov0, ir0, occ0, od0), pk(1'b0, 1'b1, 2'd0, 32'h0));

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            #1;
            chk($sformatf("vec%0d", i), pk(ov1, ir1, occ1, od1),
                pk(vecs[i].ov, vecs[i].ir, vecs[i].occ, vecs[i].od));
            step();
        end

        // single-entry stall: in_ready follows out_ready within the cycle
        do_reset();
        drive(1'b1, 32'h55550001, 1'b0, 1'b0); #1;
        chk("s0_accept", pk(ov0, ir0, occ0, od0), pk(1'b0, 1'b1, 2'd0, 32'h0));
        step();
        drive(1'b1, 32'h66660002, 1'b0, 1'b0); #1;
        chk("s0_stall", pk(ov0, ir0, occ0, od0), pk(1'b1, 1'b0, 2'd1, 32'h55550001));
        step();
        out_ready = 1'b1; #1;
        chk("s0_comb_ready", pk(ov0, ir0, occ0, od0), pk(1'b1, 1'b1, 2'd1, 32'h55550001));
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0); #1;
        chk("s0_next", pk(ov0, ir0, occ0, od0), pk(1'b1, 1'b1, 2'd1, 32'h66660002));
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0); #1;
        chk("s0_drained", pk(ov0, ir0, occ0, od0), pk(1'b0, 1'b1, 2'd0, 32'h66660002));
        step();

        // reset while the skid instance is full
        drive(1'b1, 32'h77770001, 1'b0, 1'b0); step();
        drive(1'b1, 32'h88880002, 1'b0, 1'b0); #1;
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0); #1;
        chk("pre_rst_full", pk(ov1, ir1, occ1, od1), pk(1'b1, 1'b0, 2'd2, 32'h77770001));
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        chk("rst_mid_skid1", pk(ov1, ir1, occ1, od1), pk(1'b0, 1'b1, 2'd0, 32'h0));
        chk("rst_mid_skid0", pk(ov0, ir0, occ0, od0), pk(1'b0, 1'b1, 2'd0, 32'h0));

        // random soak against two FIFO reference models
        do_reset();
        q1.delete();
        q0.delete();
        for (int c = 0; c < 10000; c++) begin
            iv   = ($urandom_range(99, 0) < 60);
            ordy = ($urandom_range(99, 0) < 60);
            fl   = ($urandom_range(99, 0) < 3);
            d    = $urandom;
            drive(iv, d, ordy, fl);
            #1;
            e1_ov = (q1.size() > 0);
            e1_ir = (q1.size() < 2);
            e0_ov = (q0.size() > 0);
            e0_ir = !e0_ov | ordy;
            chk($sformatf("soak1_c%0d", c), pk(ov1, ir1, occ1, e1_ov ? od1 : 32'h0),
                pk(e1_ov, e1_ir, 2'(q1.size()), e1_ov ? q1[0] : 32'h0));
            chk($sformatf("soak0_c%0d", c), pk(ov0, ir0, occ0, e0_ov ? od0 : 32'h0),
                pk(e0_ov, e0_ir, 2'(q0.size()), e0_ov ? q0[0] : 32'h0));
            if (fl) begin
                q1.delete();
                q0.delete();
            end else begin
                if (e1_ov && ordy) void'(q1.pop_front());
                if (iv && e1_ir) q1.push_back(d);
                if (e0_ov && ordy) void'(q0.pop_front());
                if (iv && e0_ir) q0.push_back(d);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, an optional skid entry, and flush. It replaces the fixed-field, load-enable stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the rv32i pipeline. Each stage boundary instantiates it with WIDTH set to the packed width of that stage's payload struct. Stalls propagate as ready back-pressure, and branch/exception redirects squash the stage with flush.

## Interface
- WIDTH, default 32: payload width in bits; must be at least 1.
- SKID, default 1: 1 gives a two-entry buffer with registered in_ready; 0 gives a single entry whose in_ready is combinational from out_ready.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  squash all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts the payload this cycle.
- out_data  out  WIDTH  downstream payload.
- occupancy  out  2  number of held entries: 0, 1 or 2.

## Operation
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Priority order: rst, then flush, then normal handshake.
- rst:
  - state becomes EMPTY.
  - main_data and skid_data become 0.
  - out_valid = 0, occupancy = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- flush:
  - Next state is EMPTY.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as consumed.
  - Data registers keep their values; only validity is cleared.
- State machine when SKID=1 (state type pipe_state_t):
  - EMPTY: in_fire → ONE, main_data ← in_data.
  - ONE, in_fire & out_fire → ONE, main_data ← in_data.
  - ONE, in_fire & !out_fire → FULL, skid_data ← in_data.
  - ONE, out_fire & !in_fire → EMPTY.
  - ONE, no fire → ONE, hold.
  - FULL: in_ready = 0. out_fire → ONE, main_data ← skid_data. Otherwise hold.
- Outputs when SKID=1:
  - in_ready = (state != FULL), decoded from a register.
  - out_valid = (state != EMPTY).
  - out_data = main_data.
- SKID=0:
  - States are EMPTY and ONE only; occupancy never exceeds 1.
  - in_ready = !out_valid | out_ready.
  - in_fire loads main_data and sets ONE.
  - out_fire & !in_fire → EMPTY.
- Ordering is FIFO: skid_data is always younger than main_data.
- Backward compatibility: legacy load = 0 (stall) maps to out_ready = 0 on the consuming side.

## Timing
- Latency: in_fire in cycle N gives out_valid = 1 with that payload in cycle N+1.
- Throughput: 1 payload per cycle in both modes, given sustained in_valid and out_ready.
- SKID=1 has no combinational path from out_ready to in_ready; the only paths are combinational out_valid/out_data from registers.
- Stability: while out_valid & !out_ready, out_data and out_valid stay constant in every cycle except a flush cycle.
- in_valid deasserted with in_ready low is legal; no payload is taken.
- Recovery from FULL: a single out_fire restores in_ready = 1 in the next cycle.
- Reset mid-transfer: payloads held in any entry are lost and the reset values above apply in the next cycle.
- Flush while FULL: both entries are dropped; in_ready = 1 and out_valid = 0 in the next cycle.

## Structure
- pipe_pkg holds:
  - the typedef enum pipe_state_t {PS_EMPTY, PS_ONE, PS_FULL};
  - the per-stage payload structs if_id_t, id_ex_t, ex_mem_t, mem_wb_t, built on rv32i_types (rv32i_word, rv32i_opcode, rv32i_reg_word).
- The instantiating stage sets WIDTH = $bits(if_id_t), or the equivalent struct for its boundary.
- Single module, no sub-modules.
- SKID is selected with a generate branch.
- The state register and the two data registers sit in one always_ff block; next-state and ready/valid decode sit in one always_comb block.

## Test plan
- Reset: rst for 2 cycles, release → out_valid=0, occupancy=0, out_data=0, in_ready=1.
- Streaming: in_data=0x00000013, 0x00100093, 0x00200113, one per cycle, out_ready=1 → each appears on out_data one cycle later, in order; occupancy stays at 1.
- Skid fill (SKID=1): push A=0xAAAA0001, then B=0xBBBB0002 with out_ready=0 → occupancy=2, in_ready=0, out_data=A held for 5 cycles. Raise out_ready → A then B on consecutive cycles; in_ready returns to 1 one cycle after A fires.
- Flush while FULL, with simultaneous in_valid carrying 0xCCCC0003 → next cycle out_valid=0, occupancy=0; 0xCCCC0003 never appears on out_data.
- SKID=0 stall: hold out_ready=0 with out_valid=1 → in_ready=0 in the same cycle. Toggle out_ready high → in_ready=1 combinationally, and the new payload appears the next cycle.
- Random soak: 10k cycles of random in_valid, out_ready and flush → scoreboard confirms no loss, duplication or reordering outside flushes, and occupancy always matches the model.
